// File: rtl/serial_nibble_adder_pkg.sv
// Shared types and constants for the serial nibble adder.
// Nibble width and FSM state encodings.
package serial_nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple carry adder built from a chain of full adders.
// Purely combinational.
module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/serial_nibble_adder.sv
// Wide adder that feeds one nibble per cycle, LSB first,
// through a single 4-bit ripple adder with a registered carry.
module serial_nibble_adder
  import serial_nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [WIDTH-1:0]      sum_q, sum_d;
  logic                  cout_q, cout_d;

  logic [NIBBLE_W-1:0]   a_nib, b_nib, s_nib;
  logic                  co;
  logic                  last;

  // Select the operand nibbles addressed by the index counter.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  ripple_carry_adder u_rca (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (s_nib),
    .co (co)
  );

  assign last = (idx_q == IW'(NIB - 1));

  // Next-state, operand capture and nibble accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IW'(i)) begin
            sum_d[i*NIBBLE_W +: NIBBLE_W] = s_nib;
          end
        end
        carry_d = co;
        if (last) begin
          cout_d  = co;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight add.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ADD) || (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Scoreboard bench for serial_nibble_adder (WIDTH=16).
// Driver pushes expected results; monitor pops on out handshake.
module tb_serial_nibble_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  serial_nibble_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] exp;
    logic [31:0] acc;
  } item_t;

  item_t sbq[$];
  int    errors   = 0;
  int    checks   = 0;
  int    cyc      = 0;
  int    last_acc = -1;
  bit    rnd_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one bundle; on accept push its expected result.
  task automatic send(input logic [15:0] ta,
                      input logic [15:0] tb_,
                      input logic        tc,
                      input logic [16:0] exp,
                      input bit          hold);
    bit done = 1'b0;
    a        = ta;
    b        = tb_;
    cin      = tc;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        if (last_acc >= 0)
          check("accept_spacing", 32'(cyc - last_acc >= NIB + 2), 1);
        last_acc = cyc;
        sbq.push_back('{exp: exp, acc: 32'(cyc)});
      end
    end
    if (!done) check("accept_timeout", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;
    if (hold) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (sbq.size() == 0) && in_ready;
    end
    if (!ok) check("drain_timeout", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: ordering, latency, hold-while-stalled, duplicates.
  initial begin
    logic        ov_prev = 1'b0;
    logic        or_prev = 1'b0;
    logic [16:0] held    = '0;
    item_t       it;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
        or_prev = 1'b0;
      end else begin
        if (ov_prev && !or_prev) begin
          check("hold_valid", {31'd0, out_valid}, 1);
          if (out_valid) check("hold_data", {15'd0, cout, sum}, {15'd0, held});
        end
        if (out_valid) begin
          if (sbq.size() == 0) begin
            check("spurious_valid", {31'd0, out_valid}, 0);
          end else begin
            if (!ov_prev)
              check("latency", 32'(cyc) - sbq[0].acc, NIB + 1);
            if (out_ready) begin
              it = sbq.pop_front();
              check("result", {15'd0, cout, sum}, {15'd0, it.exp});
            end
          end
        end
        ov_prev = out_valid;
        or_prev = out_ready;
        held    = {cout, sum};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int          rel;
    logic [15:0] ra, rb;
    logic        rc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_sum", {16'd0, sum}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
    send(16'h0000, 16'h0000, 1'b1, 17'h00001, 1'b0);
    send(16'h8000, 16'h8000, 1'b1, 17'h10001, 1'b0);
    wait_idle();

    out_ready = 1'b0;
    send(16'h00FF, 16'h0F0F, 1'b0, 17'h0100E, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    a        = 16'h0003;
    b        = 16'h0004;
    cin      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid}, 1);
      check("bp_in_ready", {31'd0, in_ready}, 0);
      check("bp_sum", {16'd0, sum}, 32'h100E);
      check("bp_cout", {31'd0, cout}, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rel       = cyc;
    send(16'h0003, 16'h0004, 1'b0, 17'h00007, 1'b0);
    check("accept_after_release", last_acc, rel + 1);
    wait_idle();

    send(16'h1234, 16'h1111, 1'b0, 17'h02345, 1'b0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    sbq.delete();
    last_acc = -1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_out_valid", {31'd0, out_valid}, 0);
    check("mid_sum", {16'd0, sum}, 0);
    check("mid_cout", {31'd0, cout}, 0);
    check("mid_busy", {31'd0, busy}, 0);
    check("mid_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;
    send(16'h0001, 16'h0001, 1'b0, 17'h00002, 1'b0);
    wait_idle();

    rnd_en = 1'b1;
    for (int n = 0; n < 12; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'd0, rc}, 1'b1);
    end
    in_valid = 1'b0;
    wait_idle();
    rnd_en    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("queue_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
